// File: rtl/phy_tx_sched_pkg.sv
// phy_tx_sched shared types: FSM encoding and default widths.
// Optional grant statistics are built with PHY_TX_SCHED_STATS_EN.
package phy_tx_sched_pkg;

  localparam int NUM_REQ   = 4;
  localparam int REQ_IDX_W = 2;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_INIT   = 2'd1,
    S_IDLE   = 2'd2,
    S_ACTIVE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/phy_tx_sched_rr_pick.sv
// rr_pick: find-first-set over req, scanning upward from start
// and wrapping at NUM_REQ.
module rr_pick
  import phy_tx_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] start,
  output logic                 found,
  output logic [REQ_IDX_W-1:0] idx
);

  logic [REQ_IDX_W-1:0] cand;

  // Scan farthest first so the nearest hit is the one kept.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = start + REQ_IDX_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/phy_tx_sched.sv
// Round-robin scheduler striping requester FIFOs onto two lanes.
// Define PHY_TX_SCHED_STATS_EN for per-requester grant counters.
module phy_tx_sched
  import phy_tx_sched_pkg::*;
(
  input  logic                      clk_f,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [1:0]                lane_en,
  input  logic [NUM_REQ-1:0]        req_empty,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_pop,
  output logic [DATA_W-1:0]         entrada_0,
  output logic                      validin0,
  output logic [DATA_W-1:0]         entrada_1,
  output logic                      validin1,
`ifdef PHY_TX_SCHED_STATS_EN
  output logic [NUM_REQ*CNT_W-1:0]  grant_cnt,
`endif
  output logic [1:0]                estado
);

  sched_state_t         state_q, state_d;
  logic [REQ_IDX_W-1:0] ptr_q, ptr_d;
  logic [1:0]           lane_en_q;

  logic [NUM_REQ-1:0]   nonempty, mask1;
  logic                 f0, f1;
  logic [REQ_IDX_W-1:0] i0, i1;
  logic                 go, g0, g1;
  logic                 l0_v, l1_v;
  logic [REQ_IDX_W-1:0] l0_i, l1_i;

  assign nonempty = ~req_empty;
  assign mask1    = nonempty & ~(NUM_REQ'(1) << i0);

  rr_pick u_pick0 (
    .req   (nonempty),
    .start (ptr_q),
    .found (f0),
    .idx   (i0)
  );

  rr_pick u_pick1 (
    .req   (mask1),
    .start (ptr_q),
    .found (f1),
    .idx   (i1)
  );

  assign go = (state_q == S_ACTIVE) && enable;
  assign g0 = go && f0;
  assign g1 = go && (&lane_en_q) && f1;

  // First grant goes to the lowest enabled lane.
  assign l0_v = g0 && lane_en_q[0];
  assign l0_i = i0;
  assign l1_v = lane_en_q[0] ? g1 : g0;
  assign l1_i = lane_en_q[0] ? i1 : i0;

  always_comb begin
    req_pop = '0;
    if (g0) req_pop[i0] = 1'b1;
    if (g1) req_pop[i1] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (g1)
      ptr_d = i1 + REQ_IDX_W'(1);
    else if (g0)
      ptr_d = i0 + REQ_IDX_W'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT:   if (enable) state_d = S_IDLE;
      S_IDLE:
        if ((|nonempty) && (lane_en_q != 2'b00))
          state_d = S_ACTIVE;
      S_ACTIVE: if (!(|nonempty)) state_d = S_IDLE;
      default:  state_d = S_RESET;
    endcase
    if (!enable) state_d = S_INIT;
  end

  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RESET;
      ptr_q     <= '0;
      lane_en_q <= 2'b00;
      entrada_0 <= '0;
      validin0  <= 1'b0;
      entrada_1 <= '0;
      validin1  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      if (state_q == S_INIT)
        lane_en_q <= lane_en;
      validin0  <= l0_v;
      validin1  <= l1_v;
      entrada_0 <= l0_v ? req_data[l0_i*DATA_W +: DATA_W] : '0;
      entrada_1 <= l1_v ? req_data[l1_i*DATA_W +: DATA_W] : '0;
    end
  end

  assign estado = state_q;

`ifdef PHY_TX_SCHED_STATS_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == S_INIT) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_pop[i] && (cnt_q[i] != '1))
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_phy_tx_sched.sv
// Bench for phy_tx_sched: vector table with a lane-output scoreboard,
// plus reset-in-flight and grant-counter sequences.
module tb_phy_tx_sched;

  logic        clk_f = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  lane_en;
  logic [3:0]  req_empty;
  logic [31:0] req_data;
  logic [3:0]  req_pop;
  logic [7:0]  entrada_0, entrada_1;
  logic        validin0, validin1;
  logic [1:0]  estado;
`ifdef PHY_TX_SCHED_STATS_EN
  logic [31:0] grant_cnt;
`endif

  phy_tx_sched dut (
    .clk_f     (clk_f),
    .reset     (reset),
    .enable    (enable),
    .lane_en   (lane_en),
    .req_empty (req_empty),
    .req_data  (req_data),
    .req_pop   (req_pop),
    .entrada_0 (entrada_0),
    .validin0  (validin0),
    .entrada_1 (entrada_1),
    .validin1  (validin1),
`ifdef PHY_TX_SCHED_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .estado    (estado)
  );

  always #5 clk_f = ~clk_f;

  typedef struct {
    logic       en;
    logic [1:0] lane;
    logic [3:0] emp;
    logic [1:0] st;
    logic [3:0] pop;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
  } vec_t;

  typedef struct packed {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
  } out_t;

  vec_t tv[$];
  out_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [1:0] RST = 2'd0, INI = 2'd1, IDL = 2'd2, ACT = 2'd3;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(logic en, logic [1:0] ln, logic [3:0] emp,
                     logic [1:0] st, logic [3:0] pop,
                     logic v0, logic [7:0] d0, logic v1, logic [7:0] d1);
    vec_t v;
    v.en = en; v.lane = ln; v.emp = emp; v.st = st; v.pop = pop;
    v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    tv.push_back(v);
  endtask

  task automatic run_rows(int a, int b);
    out_t e, x;
    for (int r = a; r <= b; r++) begin
      @(negedge clk_f);
      enable    = tv[r].en;
      lane_en   = tv[r].lane;
      req_empty = tv[r].emp;
      #1;
      chk($sformatf("row%0d estado", r), 32'(estado), 32'(tv[r].st));
      chk($sformatf("row%0d req_pop", r), 32'(req_pop), 32'(tv[r].pop));
      e.v0 = tv[r].v0; e.d0 = tv[r].d0;
      e.v1 = tv[r].v1; e.d1 = tv[r].d1;
      sbq.push_back(e);
      @(posedge clk_f);
      #1;
      if (sbq.size() == 0) begin
        chk($sformatf("row%0d scoreboard empty", r), 32'd1, 32'd0);
      end else begin
        x = sbq.pop_front();
        chk($sformatf("row%0d lane0", r),
            32'({validin0, entrada_0}), 32'({x.v0, x.d0}));
        chk($sformatf("row%0d lane1", r),
            32'({validin1, entrada_1}), 32'({x.v1, x.d1}));
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    lane_en   = 2'b11;
    req_empty = 4'hF;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // en lane emp st pop v0 d0 v1 d1
    add(0, 2'b11, 4'b1111, INI, 4'b0000, 0, 8'h00, 0, 8'h00); // 0
    add(0, 2'b11, 4'b1111, INI, 4'b0000, 0, 8'h00, 0, 8'h00);
    add(1, 2'b11, 4'b0000, INI, 4'b0000, 0, 8'h00, 0, 8'h00);
    add(1, 2'b11, 4'b0000, IDL, 4'b0000, 0, 8'h00, 0, 8'h00);
    add(1, 2'b11, 4'b0000, ACT, 4'b0011, 1, 8'hA0, 1, 8'hA1); // 4
    add(1, 2'b11, 4'b0000, ACT, 4'b1100, 1, 8'hA2, 1, 8'hA3);
    add(1, 2'b11, 4'b0000, ACT, 4'b0011, 1, 8'hA0, 1, 8'hA1);
    add(1, 2'b11, 4'b0000, ACT, 4'b1100, 1, 8'hA2, 1, 8'hA3);
    add(1, 2'b11, 4'b1011, ACT, 4'b0100, 1, 8'hA2, 0, 8'h00); // 8
    add(1, 2'b11, 4'b0000, ACT, 4'b1001, 1, 8'hA3, 1, 8'hA0);
    add(1, 2'b11, 4'b1111, ACT, 4'b0000, 0, 8'h00, 0, 8'h00);
    add(1, 2'b11, 4'b1111, IDL, 4'b0000, 0, 8'h00, 0, 8'h00);
    add(0, 2'b10, 4'b1111, IDL, 4'b0000, 0, 8'h00, 0, 8'h00); // 12
    add(0, 2'b10, 4'b1111, INI, 4'b0000, 0, 8'h00, 0, 8'h00);
    add(1, 2'b10, 4'b0000, INI, 4'b0000, 0, 8'h00, 0, 8'h00);
    add(1, 2'b01, 4'b0000, IDL, 4'b0000, 0, 8'h00, 0, 8'h00);
    add(1, 2'b01, 4'b0000, ACT, 4'b0010, 0, 8'h00, 1, 8'hA1); // 16
    add(1, 2'b11, 4'b0000, ACT, 4'b0100, 0, 8'h00, 1, 8'hA2);
    add(0, 2'b11, 4'b0000, ACT, 4'b0000, 0, 8'h00, 0, 8'h00);
    add(0, 2'b11, 4'b0000, INI, 4'b0000, 0, 8'h00, 0, 8'h00);
    add(1, 2'b11, 4'b0000, INI, 4'b0000, 0, 8'h00, 0, 8'h00); // 20
    add(1, 2'b11, 4'b0000, IDL, 4'b0000, 0, 8'h00, 0, 8'h00);
    add(1, 2'b11, 4'b0000, ACT, 4'b1001, 1, 8'hA3, 1, 8'hA0);
    add(1, 2'b11, 4'b0000, ACT, 4'b0110, 1, 8'hA1, 1, 8'hA2);
    add(1, 2'b11, 4'b0000, INI, 4'b0000, 0, 8'h00, 0, 8'h00); // 24
    add(1, 2'b11, 4'b0000, IDL, 4'b0000, 0, 8'h00, 0, 8'h00);
    add(1, 2'b11, 4'b0000, ACT, 4'b0011, 1, 8'hA0, 1, 8'hA1);
    add(0, 2'b11, 4'b0000, ACT, 4'b0000, 0, 8'h00, 0, 8'h00);

    repeat (2) @(posedge clk_f);
    #1;
    chk("reset estado", 32'(estado), 32'(RST));
    chk("reset req_pop", 32'(req_pop), 32'd0);
    chk("reset lanes",
        32'({validin0, entrada_0, validin1, entrada_1}), 32'd0);

    @(negedge clk_f);
    reset = 1'b1;
    run_rows(0, 23);

    // Async reset between edges while lanes are carrying data.
    #2;
    reset = 1'b0;
    #1;
    chk("async rst lanes",
        32'({validin0, entrada_0, validin1, entrada_1}), 32'd0);
    chk("async rst req_pop", 32'(req_pop), 32'd0);
    chk("async rst estado", 32'(estado), 32'(RST));
    @(negedge clk_f);
    reset = 1'b1;
    run_rows(24, 27);

`ifdef PHY_TX_SCHED_STATS_EN
    @(negedge clk_f);
    enable    = 1'b1;
    lane_en   = 2'b01;
    req_empty = 4'b1110;
    repeat (2) @(posedge clk_f);
    repeat (100) @(posedge clk_f);
    #1;
    chk("cnt0 after 100", grant_cnt[7:0], 32'd100);
    repeat (200) @(posedge clk_f);
    #1;
    chk("cnt0 saturated", grant_cnt[7:0], 32'd255);
    chk("cnt1..3 zero", 32'(grant_cnt[31:8]), 32'd0);
    @(negedge clk_f);
    enable = 1'b0;
    repeat (2) @(posedge clk_f);
    #1;
    chk("cnt cleared in INIT", grant_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
